// File: rtl/mat_mul_sequencer.sv
// Control sequencer for a complex N x N matrix product: walks result elements in row-major
// order and issues the four partial products (RR, II, RI, IR) plus a real and an imag write.

`ifndef WORD_LEN
`define WORD_LEN 16
`endif
`ifndef MATRIX_DIM
`define MATRIX_DIM 2
`endif

module mat_mul_sequencer #(
  parameter int unsigned WORD_LEN   = `WORD_LEN,
  parameter int unsigned MATRIX_DIM = `MATRIX_DIM,
  localparam int unsigned IDX_W     = ($clog2(MATRIX_DIM) > 1) ? $clog2(MATRIX_DIM) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             issue_ready,
  output logic             issue_valid,
  output logic [IDX_W-1:0] row_idx,
  output logic [IDX_W-1:0] col_idx,
  output logic [1:0]       blk_sel,
  output logic             acc_clr,
  output logic             acc_sub,
  output logic             res_wr,
  output logic             res_imag,
  output logic             busy,
  output logic             done
);

  if (MATRIX_DIM < 2 || WORD_LEN < 1) begin : gen_param_check
    $error("mat_mul_sequencer: MATRIX_DIM must be >= 2 and WORD_LEN >= 1");
  end

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(MATRIX_DIM - 1);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StPh0  = 3'd1,
    StPh1  = 3'd2,
    StWrr  = 3'd3,
    StPh2  = 3'd4,
    StPh3  = 3'd5,
    StWri  = 3'd6,
    StDone = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] row_q, row_d;
  logic [IDX_W-1:0] col_q, col_d;
  logic             accept;

  assign accept = issue_valid & issue_ready;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d = StPh0;
          row_d   = '0;
          col_d   = '0;
        end
      end
      StPh0:  if (accept) state_d = StPh1;
      StPh1:  if (accept) state_d = StWrr;
      StWrr:  state_d = StPh2;
      StPh2:  if (accept) state_d = StPh3;
      StPh3:  if (accept) state_d = StWri;
      StWri: begin
        // Indices stay on the last element so they read (N-1, N-1) after completion.
        if (row_q == LastIdx && col_q == LastIdx) begin
          state_d = StDone;
        end else begin
          state_d = StPh0;
          if (col_q == LastIdx) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Abort wins over any handshake or write in the same cycle.
    if (abort && state_q != StIdle) state_d = StIdle;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    issue_valid = 1'b0;
    blk_sel     = 2'b00;
    acc_clr     = 1'b0;
    acc_sub     = 1'b0;
    res_wr      = 1'b0;
    res_imag    = 1'b0;
    done        = 1'b0;
    case (state_q)
      StPh0: begin
        issue_valid = 1'b1;
        blk_sel     = 2'b00;
        acc_clr     = 1'b1;
      end
      StPh1: begin
        issue_valid = 1'b1;
        blk_sel     = 2'b01;
        acc_sub     = 1'b1;
      end
      StWrr: res_wr = 1'b1;
      StPh2: begin
        issue_valid = 1'b1;
        blk_sel     = 2'b10;
        acc_clr     = 1'b1;
      end
      StPh3: begin
        issue_valid = 1'b1;
        blk_sel     = 2'b11;
      end
      StWri: begin
        res_wr   = 1'b1;
        res_imag = 1'b1;
      end
      StDone: done = 1'b1;
      default: ;
    endcase
  end

  assign busy    = (state_q != StIdle);
  assign row_idx = row_q;
  assign col_idx = col_q;

endmodule

// File: tb/tb_mat_mul_sequencer.sv
// Directed bench for mat_mul_sequencer (N=2): per-cycle output model plus hand-computed
// write order, completion latency, backpressure, abort, start-while-busy and reset cases.

module tb_mat_mul_sequencer;
  localparam int N = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       issue_ready = 1'b1;
  logic       issue_valid;
  logic [0:0] row_idx;
  logic [0:0] col_idx;
  logic [1:0] blk_sel;
  logic       acc_clr, acc_sub, res_wr, res_imag, busy, done;

  int total = 0;
  int bad = 0;
  logic [2:0] wr_log[$];

  mat_mul_sequencer #(
    .WORD_LEN  (16),
    .MATRIX_DIM(N)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .issue_ready(issue_ready),
    .issue_valid(issue_valid),
    .row_idx    (row_idx),
    .col_idx    (col_idx),
    .blk_sel    (blk_sel),
    .acc_clr    (acc_clr),
    .acc_sub    (acc_sub),
    .res_wr     (res_wr),
    .res_imag   (res_imag),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] outs();
    return {busy, done, issue_valid, row_idx, col_idx, blk_sel, acc_clr, acc_sub, res_wr,
            res_imag};
  endfunction

  // e < N*N: element e in phase ph (0 PH0,1 PH1,2 WRR,3 PH2,4 PH3,5 WRI);
  // e == N*N: DONE; beyond: IDLE. Indices rest on (N-1, N-1) after completion.
  function automatic logic [10:0] model_vec(input int ph, input int e);
    logic [10:0] v;
    v = '0;
    if (e < N * N) begin
      v[10]  = 1'b1;
      v[8]   = (ph == 0 || ph == 1 || ph == 3 || ph == 4);
      v[7]   = 1'(e / N);
      v[6]   = 1'(e % N);
      v[5:4] = (ph == 1) ? 2'b01 : (ph == 3) ? 2'b10 : (ph == 4) ? 2'b11 : 2'b00;
      v[3]   = (ph == 0 || ph == 3);
      v[2]   = (ph == 1);
      v[1]   = (ph == 2 || ph == 5);
      v[0]   = (ph == 5);
    end else begin
      v[10] = (e == N * N);
      v[9]  = (e == N * N);
      v[7]  = 1'b1;
      v[6]  = 1'b1;
    end
    return v;
  endfunction

  // Pulse start, then run 40 cycles. Cycle 1 is the one right after the start-sampling edge.
  task automatic run(input int stall_at, input int stall_len, input int start2_at,
                     input int abort_at, output int done_cyc, output int n_done);
    int ph = 0;
    int e = 0;
    bit active = 1'b1;
    bit after_abort = 1'b0;
    wr_log.delete();
    done_cyc = -1;
    n_done = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (active) check_eq($sformatf("outs_c%0d", cyc), 32'(outs()), 32'(model_vec(ph, e)));
      if (after_abort) begin
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_wr", 32'(res_wr), 32'd0);
        after_abort = 1'b0;
      end
      if (res_wr) wr_log.push_back({row_idx, col_idx, res_imag});
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      issue_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      start = (cyc == start2_at);
      abort = (cyc == abort_at);
      if (abort) begin
        active = 1'b0;
        after_abort = 1'b1;
      end else if (e < N * N) begin
        if (!((ph == 0 || ph == 1 || ph == 3 || ph == 4) && !issue_ready)) begin
          ph++;
          if (ph == 6) begin
            ph = 0;
            e++;
          end
        end
      end else begin
        e = N * N + 1;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    abort = 1'b0;
    issue_ready = 1'b1;
  endtask

  task automatic check_writes(input string tag, input int n);
    check_eq({tag, "_nwr"}, 32'(wr_log.size()), 32'(n));
    for (int k = 0; k < n && k < wr_log.size(); k++)
      check_eq($sformatf("%s_wr%0d", tag, k), 32'(wr_log[k]), 32'(k));
  endtask

  initial begin
    int dc, nd;
    #1;
    check_eq("rst_outs", 32'(outs()), 32'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_rst_idle", 32'(outs()), 32'd0);

    // Full product, no backpressure: order is (0,0)R,(0,0)I,(0,1)R,... i.e. {r,c,i} = k.
    run(0, 0, 0, 0, dc, nd);
    check_eq("full_done_cyc", 32'(dc), 32'd25);
    check_eq("full_n_done", 32'(nd), 32'd1);
    check_writes("full", 8);

    // Three stalled cycles in PH1 of element (0,0).
    run(2, 3, 0, 0, dc, nd);
    check_eq("stall_done_cyc", 32'(dc), 32'd28);
    check_eq("stall_n_done", 32'(nd), 32'd1);
    check_writes("stall", 8);

    // Second start during WRR of element (0,0) is ignored.
    run(0, 0, 3, 0, dc, nd);
    check_eq("start2_done_cyc", 32'(dc), 32'd25);
    check_eq("start2_n_done", 32'(nd), 32'd1);

    // Abort in PH3 of element (0,1) (cycle 11) while issue_ready=1.
    run(0, 0, 0, 11, dc, nd);
    check_eq("abort_n_done", 32'(nd), 32'd0);
    check_writes("abort", 3);

    // Restart after abort begins from (0,0).
    run(0, 0, 0, 0, dc, nd);
    check_eq("restart_done_cyc", 32'(dc), 32'd25);
    check_writes("restart", 8);

    // start and abort together in IDLE.
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("st_ab_busy%0d", i), 32'(busy), 32'd0);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset in the middle of PH2 (cycle 4).
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("pre_rst_ph2", 32'({issue_valid, blk_sel, acc_clr}), 32'b1101);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_outs", 32'(outs()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_eq($sformatf("rst_wait%0d", i), 32'(busy), 32'd0);
    end
    run(0, 0, 0, 0, dc, nd);
    check_eq("after_rst_done_cyc", 32'(dc), 32'd25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mat_mul_sequencer.md
MAT_MUL_SEQUENCER -- requirements
Module: mat_mul_sequencer

Interface
REQ-001 The block SHALL have parameter WORD_LEN, default `WORD_LEN, the operand word width (informational; no datapath inside this block).
REQ-002 The block SHALL have parameter MATRIX_DIM, default `MATRIX_DIM, the square matrix dimension N (N >= 2).
REQ-003 The block SHALL have derived localparam IDX_W = max(1, clog2(MATRIX_DIM)), the index width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: request to begin one full complex N x N product.
REQ-007 The block SHALL have port abort, input, 1 bit: synchronous cancel of a running product.
REQ-008 The block SHALL have port issue_ready, input, 1 bit: the datapath accepts the current issue.
REQ-009 The block SHALL have port issue_valid, output, 1 bit: the issue fields below are valid.
REQ-010 The block SHALL have port row_idx, output, IDX_W bits: the M1 row to present on Br_m1/Bi_m1.
REQ-011 The block SHALL have port col_idx, output, IDX_W bits: the M2 column to present on Br_m2/Bi_m2.
REQ-012 The block SHALL have port blk_sel, output, 2 bits: 00 Br_m1*Br_m2, 01 Bi_m1*Bi_m2, 10 Br_m1*Bi_m2, 11 Bi_m1*Br_m2.
REQ-013 The block SHALL have port acc_clr, output, 1 bit: accumulator loads rather than adds on this issue.
REQ-014 The block SHALL have port acc_sub, output, 1 bit: the product is subtracted from the accumulator.
REQ-015 The block SHALL have port res_wr, output, 1 bit: write the accumulator to result element (row_idx, col_idx).
REQ-016 The block SHALL have port res_imag, output, 1 bit: the written part, 0 = real and 1 = imag.
REQ-017 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-018 The block SHALL have port done, output, 1 bit: a one-cycle pulse marking product completion.

Function
REQ-019 The block SHALL implement states IDLE, PH0, PH1, WRR, PH2, PH3, WRI, DONE, held in a registered FSM with all outputs registered or decoded from registered state and counters.
REQ-020 In IDLE with start=1, the block SHALL clear row_idx and col_idx and enter PH0 at the next edge; start in any other state SHALL be ignored.
REQ-021 In PH0..PH3 the block SHALL drive issue_valid=1 with blk_sel = 00, 01, 10, 11 respectively.
REQ-022 The block SHALL assert acc_clr in PH0 and PH2 only.
REQ-023 The block SHALL assert acc_sub in PH1 only, so that real = RR - II and imag = RI + IR.
REQ-024 A phase state SHALL advance only on a cycle with issue_valid and issue_ready both high.
REQ-025 While issue_valid=1 and issue_ready=0, the block SHALL hold issue_valid, row_idx, col_idx, blk_sel, acc_clr and acc_sub stable.
REQ-026 Accepting PH1 SHALL lead to WRR and accepting PH3 SHALL lead to WRI, each lasting exactly one cycle with res_wr=1.
REQ-027 res_imag SHALL be 0 in WRR and 1 in WRI; issue_valid SHALL be 0 in both.
REQ-028 WRR SHALL lead to PH2.
REQ-029 WRI SHALL increment col_idx; on wrap from N-1 to 0 it SHALL increment row_idx, giving row-major order.
REQ-030 WRI at element (N-1, N-1) SHALL lead to DONE instead of PH0.
REQ-031 DONE SHALL last one cycle with done=1 and then return to IDLE; index counters SHALL hold their final values.
REQ-032 With issue_ready held at 1, the block SHALL take 6 cycles per element, with done asserted exactly 6*N*N+1 cycles after the edge that sampled start.
REQ-033 abort=1 in any non-IDLE state SHALL force IDLE at the next edge with no res_wr and no done; abort SHALL take priority over a handshake in the same cycle.
REQ-034 abort in IDLE SHALL have no effect; start and abort both high in IDLE SHALL leave the block in IDLE.
REQ-035 Illegal state encodings SHALL recover to IDLE.

Reset
REQ-036 While rst_n=0, the block SHALL asynchronously force state=IDLE and drive all outputs to 0 (issue_valid, row_idx, col_idx, blk_sel, acc_clr, acc_sub, res_wr, res_imag, busy, done).
REQ-037 Reset asserted mid-operation SHALL discard progress; after release the block SHALL wait for a fresh start.
REQ-038 Deassertion of rst_n SHALL be effective at the first following clk edge.

Verification
REQ-039 Reset check: assert rst_n=0 mid-PH2 -> all outputs read 0 immediately, without waiting for a clock edge.
REQ-040 Full product, N=2, issue_ready=1: pulse start -> 8 res_wr pulses in order (0,0)R,(0,0)I,(0,1)R,(0,1)I,(1,0)R,(1,0)I,(1,1)R,(1,1)I, and done at cycle 25.
REQ-041 Backpressure: issue_ready=0 for 3 cycles in PH1 -> fields stable for 3 cycles, blk_sel=01, acc_sub=1, and total latency grows by 3.
REQ-042 Start while busy: second start pulse in WRR -> ignored, with exactly one done.
REQ-043 Abort: abort=1 with issue_ready=1 in PH3 of element (0,1) -> next cycle IDLE, busy=0, no WRI write; a following start restarts at (0,0).
REQ-044 Simultaneous events: start=1 and abort=1 in IDLE -> busy stays 0.
